// File: rtl/core_bus_arbiter.sv
// Serialises the core's fetch (ibus) and data (dbus) request streams onto a single
// memory channel with one outstanding transaction and a bounded data-side priority.
module core_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_data_ok,
    output logic [31:0]       i_data,

    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [63:0]       d_wdata,
    output logic              d_data_ok,
    output logic [63:0]       d_rdata,

    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [63:0]       m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [63:0]       m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);
    localparam logic [3:0] STREAK_SAT   = 4'd15;

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    owner_t            owner_nxt;
    logic [3:0]        streak;
    logic [3:0]        streak_nxt;

    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_size;
    logic [7:0]        lat_strobe;
    logic [63:0]       lat_wdata;

    logic              gnt_d;
    logic              gnt_i;
    logic              resp;

    // Arbitration, response detection and next-state logic
    always_comb begin
        gnt_d      = 1'b0;
        gnt_i      = 1'b0;
        resp       = 1'b0;
        state_nxt  = state;
        owner_nxt  = owner;
        streak_nxt = streak;

        unique case (state)
            ST_IDLE: begin
                gnt_d = d_valid && (!i_valid || (streak < STREAK_LIMIT));
                gnt_i = !gnt_d && i_valid;
                if (gnt_d) begin
                    state_nxt  = ST_REQ;
                    owner_nxt  = OWN_D;
                    if (i_valid) begin
                        streak_nxt = (streak == STREAK_SAT) ? STREAK_SAT : streak + 4'd1;
                    end else begin
                        streak_nxt = 4'd0;
                    end
                end else if (gnt_i) begin
                    state_nxt  = ST_REQ;
                    owner_nxt  = OWN_I;
                    streak_nxt = 4'd0;
                end
            end
            ST_REQ: begin
                // A response is only meaningful once the memory has taken the request.
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        resp      = 1'b1;
                        state_nxt = ST_IDLE;
                        owner_nxt = OWN_NONE;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (m_data_ok) begin
                    resp      = 1'b1;
                    state_nxt = ST_IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            owner  <= OWN_NONE;
            streak <= 4'd0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            streak <= streak_nxt;
        end
    end

    // Request latch: captured on the grant edge, ignores requester payload afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr   <= '0;
            lat_size   <= 3'd0;
            lat_strobe <= 8'd0;
            lat_wdata  <= 64'd0;
        end else if (gnt_d) begin
            lat_addr   <= d_addr;
            lat_size   <= d_size;
            lat_strobe <= d_strobe;
            lat_wdata  <= d_wdata;
        end else if (gnt_i) begin
            lat_addr   <= i_addr;
            lat_size   <= 3'd2;
            lat_strobe <= 8'd0;
            lat_wdata  <= 64'd0;
        end
    end

    assign m_valid  = (state == ST_REQ);
    assign m_addr   = lat_addr;
    assign m_size   = lat_size;
    assign m_strobe = lat_strobe;
    assign m_wdata  = lat_wdata;

    // Response routing: only the owner sees its pulse, data is zero otherwise
    always_comb begin
        i_data_ok = resp && (owner == OWN_I);
        d_data_ok = resp && (owner == OWN_D);
        i_data    = 32'd0;
        d_rdata   = 64'd0;
        if (i_data_ok) begin
            i_data = lat_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
        end
        if (d_data_ok) begin
            d_rdata = m_rdata;
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Randomised scoreboard bench for core_bus_arbiter: a transaction-level model predicts
// grant order, memory requests and routed responses; a monitor compares against the DUT.
module tb_core_bus_arbiter;

    localparam int ADDR_W  = 64;
    localparam int MAX_D   = 4;

    logic              clk;
    logic              reset;
    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_data_ok;
    logic [31:0]       i_data;
    logic              d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_size;
    logic [7:0]        d_strobe;
    logic [63:0]       d_wdata;
    logic              d_data_ok;
    logic [63:0]       d_rdata;
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_size;
    logic [7:0]        m_strobe;
    logic [63:0]       m_wdata;
    logic              m_addr_ok;
    logic              m_data_ok;
    logic [63:0]       m_rdata;

    core_bus_arbiter #(.ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } rsp_t;

    int   total = 0;
    int   bad   = 0;
    int   n_i_done = 0;
    int   n_d_done = 0;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    bit   ch_free = 1'b1;
    int   streak  = 0;
    bit   mv_due  = 1'b0;
    bit   i_ok_q  = 1'b0;
    bit   d_ok_q  = 1'b0;

    int   i_rate = 0;
    int   d_rate = 0;
    bit   zero_mem = 1'b0;
    bit   mem_busy = 1'b0;
    int   mem_cnt  = 0;
    logic [63:0] mem_addr = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC3A5_5A3C, a[63:32] + a[31:0] + 32'h1357_9BDF};
    endfunction

    // Monitor and reference model, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            i_ok_q = i_data_ok;
            d_ok_q = d_data_ok;
            if (!reset) begin
                exp_req.delete();
                exp_rsp.delete();
                ch_free = 1'b1;
                streak  = 0;
                mv_due  = 1'b0;
            end else begin
                if (!i_data_ok) chk("i_data_zero_when_idle", {32'd0, i_data}, 64'd0);
                if (!d_data_ok) chk("d_rdata_zero_when_idle", d_rdata, 64'd0);
                if (mv_due) chk("m_valid_after_grant", {63'd0, m_valid}, 64'd1);
                mv_due = 1'b0;
                if (ch_free) chk("m_valid_low_when_free", {63'd0, m_valid}, 64'd0);
                if (i_data_ok && d_data_ok) chk("both_data_ok", 64'd1, 64'd0);

                if (m_valid && m_addr_ok) begin
                    chk("req_expected", {63'd0, exp_req.size() > 0}, 64'd1);
                    if (exp_req.size() > 0) begin
                        req_t r;
                        r = exp_req.pop_front();
                        chk("m_addr", m_addr, r.addr);
                        chk("m_size", {61'd0, m_size}, {61'd0, r.size});
                        chk("m_strobe", {56'd0, m_strobe}, {56'd0, r.strobe});
                        chk("m_wdata", m_wdata, r.wdata);
                    end
                end

                if (i_data_ok || d_data_ok) begin
                    chk("rsp_expected", {63'd0, exp_rsp.size() > 0}, 64'd1);
                    if (exp_rsp.size() > 0) begin
                        rsp_t e;
                        e = exp_rsp.pop_front();
                        chk("rsp_owner_is_d", {63'd0, d_data_ok}, {63'd0, e.is_d});
                        if (i_data_ok) chk("i_data", {32'd0, i_data}, e.data);
                        if (d_data_ok) chk("d_rdata", d_rdata, e.data);
                    end
                    if (i_data_ok) n_i_done++;
                    if (d_data_ok) n_d_done++;
                end

                // Channel free: pick a winner from the requests visible right now.
                if (ch_free) begin
                    if (d_valid && (!i_valid || streak < MAX_D)) begin
                        req_t r;
                        rsp_t e;
                        r.addr = d_addr; r.size = d_size; r.strobe = d_strobe; r.wdata = d_wdata;
                        e.is_d = 1'b1; e.data = mem_word(d_addr);
                        exp_req.push_back(r);
                        exp_rsp.push_back(e);
                        streak  = i_valid ? ((streak < 15) ? streak + 1 : 15) : 0;
                        ch_free = 1'b0;
                        mv_due  = 1'b1;
                    end else if (i_valid) begin
                        req_t r;
                        rsp_t e;
                        logic [63:0] w;
                        w = mem_word(i_addr);
                        r.addr = i_addr; r.size = 3'd2; r.strobe = 8'd0; r.wdata = 64'd0;
                        e.is_d = 1'b0; e.data = {32'd0, i_addr[2] ? w[63:32] : w[31:0]};
                        exp_req.push_back(r);
                        exp_rsp.push_back(e);
                        streak  = 0;
                        ch_free = 1'b0;
                        mv_due  = 1'b1;
                    end
                end
                if (i_data_ok || d_data_ok) ch_free = 1'b1;
            end
        end
    end

    // One clock of requester and memory behaviour.
    task automatic step();
        int dly;
        @(posedge clk);
        #1;
        if (i_valid && i_ok_q) i_valid = 1'b0;
        if (i_valid) begin
            if ($urandom_range(3) == 0) i_addr = {$urandom, $urandom};
        end else if ($urandom_range(99) < i_rate) begin
            i_valid = 1'b1;
            i_addr  = {$urandom, $urandom};
        end
        if (d_valid && d_ok_q) d_valid = 1'b0;
        if (d_valid) begin
            if ($urandom_range(3) == 0) d_wdata = {$urandom, $urandom};
        end else if ($urandom_range(99) < d_rate) begin
            d_valid  = 1'b1;
            d_addr   = {$urandom, $urandom};
            d_size   = 3'($urandom_range(7));
            d_strobe = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(255));
            d_wdata  = {$urandom, $urandom};
        end

        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = {$urandom, $urandom};
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                m_data_ok = 1'b1;
                m_rdata   = mem_word(mem_addr);
                mem_busy  = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (m_valid && (zero_mem || $urandom_range(9) < 7)) begin
            m_addr_ok = 1'b1;
            mem_addr  = m_addr;
            dly = zero_mem ? 0 : $urandom_range(2);
            if (dly == 0) begin
                m_data_ok = 1'b1;
                m_rdata   = mem_word(m_addr);
            end else begin
                mem_busy = 1'b1;
                mem_cnt  = dly - 1;
            end
        end
    endtask

    task automatic run(input int cycles, input int ir, input int dr, input bit zm);
        i_rate = ir; d_rate = dr; zero_mem = zm;
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic drain();
        int budget;
        i_rate = 0; d_rate = 0;
        budget = 300;
        while ((i_valid || d_valid || mem_busy) && budget > 0) begin
            step();
            budget--;
        end
        chk("drain_in_budget", {63'd0, budget > 0}, 64'd1);
        repeat (2) step();
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_size = 3'd0; d_strobe = 8'd0; d_wdata = 64'd0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk("rst_m_size", {61'd0, m_size}, 64'd0);
        chk("rst_m_strobe", {56'd0, m_strobe}, 64'd0);
        chk("rst_m_wdata", m_wdata, 64'd0);
        chk("rst_data_ok", {62'd0, i_data_ok, d_data_ok}, 64'd0);
        reset = 1'b1;

        run(600, 40, 40, 1'b0);
        run(400, 100, 100, 1'b0);
        run(150, 100, 0, 1'b1);
        run(150, 100, 100, 1'b1);
        run(300, 30, 70, 1'b0);
        drain();

        // Reset while a data transaction is waiting for its response.
        @(posedge clk);
        #1;
        d_valid = 1'b1; d_addr = 64'h100; d_size = 3'd3; d_strobe = 8'hFF; d_wdata = 64'hDEAD;
        @(posedge clk);
        #1;
        chk("dir_req_m_valid", {63'd0, m_valid}, 64'd1);
        chk("dir_req_m_addr", m_addr, 64'h100);
        chk("dir_req_m_strobe", {56'd0, m_strobe}, 64'hFF);
        m_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        m_addr_ok = 1'b0;
        chk("dir_wait_m_valid", {63'd0, m_valid}, 64'd0);
        m_data_ok = 1'b1;
        m_rdata   = 64'hA5A5_5A5A_0F0F_F0F0;
        reset     = 1'b0;
        #1;
        chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("midrst_d_data_ok", {63'd0, d_data_ok}, 64'd0);
        chk("midrst_d_rdata", d_rdata, 64'd0);
        chk("midrst_m_addr", m_addr, 64'd0);
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("stale_i_data_ok", {63'd0, i_data_ok}, 64'd0);
        chk("stale_d_data_ok", {63'd0, d_data_ok}, 64'd0);
        @(posedge clk);
        #1;
        m_data_ok = 1'b0;
        mem_busy  = 1'b0;

        run(300, 40, 50, 1'b0);
        drain();
        chk("fetches_completed", {63'd0, n_i_done > 50}, 64'd1);
        chk("data_completed", {63'd0, n_d_done > 50}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
